fwd_hazard_ctrl: RTL

- Control-side partner of the pipeline forwarding muxes. Generates the 2-bit operand selectors they consume, plus the load-use stall.
- Tracks the destination register, RegWrite and MemRead of the instructions in the EX, MEM and WB stages using its own shadow pipeline.
- Sits beside the ID/EX boundary. Inputs come from decode; ForwardA/ForwardB drive the EX-stage operand muxes.

---
 rtl/fwd_hazard_ctrl_pkg.sv | 20 ++
 rtl/fwd_hazard_ctrl_fwd_select.sv | 33 +++
 rtl/fwd_hazard_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types for the forwarding / load-use hazard controller.
package fwd_hazard_ctrl_pkg;

   localparam logic [1:0] FWD_REGFILE = 2'd0;
   localparam logic [1:0] FWD_EXMEM   = 2'd1;
   localparam logic [1:0] FWD_MEMWB   = 2'd2;

   // Control flags carried by every shadow stage record.
   typedef struct packed {
      logic valid;
      logic reg_write;
      logic mem_read;
   } stage_flags_t;

   typedef enum logic {
      StRun,
      StStall
   } state_t;

endpackage

// File: rtl/fwd_hazard_ctrl_fwd_select.sv
// Priority compare for one EX operand: MEM-stage producer beats WB-stage producer.
module fwd_hazard_ctrl_fwd_select
   import fwd_hazard_ctrl_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned WB_FWD_EN  = 1
) (
   input  logic                  en,
   input  logic [REG_ADDR_W-1:0] src,
   input  logic                  mem_wr,
   input  logic [REG_ADDR_W-1:0] mem_dest,
   input  logic                  wb_wr,
   input  logic [REG_ADDR_W-1:0] wb_dest,
   output logic [1:0]            sel
);

   logic mem_hit;
   logic wb_hit;

   // r0 is hardwired zero, so a producer targeting it never forwards.
   assign mem_hit = en && mem_wr && (mem_dest != '0) && (mem_dest == src);
   assign wb_hit  = en && (WB_FWD_EN != 0) && wb_wr && (wb_dest != '0) && (wb_dest == src);

   always_comb begin
      sel = FWD_REGFILE;
      if (mem_hit) begin
         sel = FWD_EXMEM;
      end else if (wb_hit) begin
         sel = FWD_MEMWB;
      end
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Shadow EX/MEM/WB pipeline driving forwarding selectors and the load-use stall.
module fwd_hazard_ctrl
   import fwd_hazard_ctrl_pkg::*;
#(
   parameter int unsigned REG_ADDR_W   = 5,
   parameter int unsigned STALL_CYCLES = 1,
   parameter int unsigned WB_FWD_EN    = 1
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  IdValid,
   input  logic [REG_ADDR_W-1:0] IdRs,
   input  logic [REG_ADDR_W-1:0] IdRt,
   input  logic                  IdUsesRt,
   input  logic [REG_ADDR_W-1:0] IdDest,
   input  logic                  IdRegWrite,
   input  logic                  IdMemRead,
   input  logic                  Flush,
   input  logic                  Freeze,
   output logic                  Stall,
   output logic [1:0]            ForwardA,
   output logic [1:0]            ForwardB,
   output logic [REG_ADDR_W-1:0] WbDest,
   output logic                  WbRegWrite
);

   localparam logic [2:0] CntInit = 3'(STALL_CYCLES - 2);

   stage_flags_t          ex_flags_q, mem_flags_q, wb_flags_q;
   logic [REG_ADDR_W-1:0] ex_rs_q, ex_rt_q, ex_dest_q, mem_dest_q, wb_dest_q;
   logic                  ex_uses_rt_q;
   state_t                state_q;
   logic [2:0]            cnt_q;
   logic                  hazard;
   logic                  unused_wb_mem_read;

   assign unused_wb_mem_read = wb_flags_q.mem_read;

   assign hazard = IdValid && ex_flags_q.valid && ex_flags_q.mem_read && (ex_dest_q != '0) &&
                   ((ex_dest_q == IdRs) || (IdUsesRt && (ex_dest_q == IdRt)));

   always_comb begin
      Stall = 1'b0;
      if (!Flush) begin
         Stall = (state_q == StStall) ? 1'b1 : hazard;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         ex_flags_q   <= '0;
         ex_rs_q      <= '0;
         ex_rt_q      <= '0;
         ex_uses_rt_q <= 1'b0;
         ex_dest_q    <= '0;
         mem_flags_q  <= '0;
         mem_dest_q   <= '0;
         wb_flags_q   <= '0;
         wb_dest_q    <= '0;
         state_q      <= StRun;
         cnt_q        <= '0;
      end else if (!Freeze) begin
         wb_flags_q  <= mem_flags_q;
         wb_dest_q   <= mem_dest_q;
         mem_flags_q <= ex_flags_q;
         mem_dest_q  <= ex_dest_q;
         if (Stall || Flush || !IdValid) begin
            ex_flags_q   <= '0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_uses_rt_q <= 1'b0;
            ex_dest_q    <= '0;
         end else begin
            ex_flags_q   <= '{valid: 1'b1, reg_write: IdRegWrite, mem_read: IdMemRead};
            ex_rs_q      <= IdRs;
            ex_rt_q      <= IdRt;
            ex_uses_rt_q <= IdUsesRt;
            ex_dest_q    <= IdDest;
         end
         if (Flush) begin
            state_q <= StRun;
            cnt_q   <= '0;
         end else begin
            unique case (state_q)
               StRun: begin
                  if (Stall && (STALL_CYCLES > 1)) begin
                     state_q <= StStall;
                     cnt_q   <= CntInit;
                  end
               end
               StStall: begin
                  if (cnt_q == '0) begin
                     state_q <= StRun;
                  end else begin
                     cnt_q <= cnt_q - 3'd1;
                  end
               end
               default: state_q <= StRun;
            endcase
         end
      end
   end

   fwd_hazard_ctrl_fwd_select #(
      .REG_ADDR_W (REG_ADDR_W),
      .WB_FWD_EN  (WB_FWD_EN)
   ) u_fwd_a (
      .en       (1'b1),
      .src      (ex_rs_q),
      .mem_wr   (mem_flags_q.valid && mem_flags_q.reg_write),
      .mem_dest (mem_dest_q),
      .wb_wr    (wb_flags_q.valid && wb_flags_q.reg_write),
      .wb_dest  (wb_dest_q),
      .sel      (ForwardA)
   );

   fwd_hazard_ctrl_fwd_select #(
      .REG_ADDR_W (REG_ADDR_W),
      .WB_FWD_EN  (WB_FWD_EN)
   ) u_fwd_b (
      .en       (ex_uses_rt_q),
      .src      (ex_rt_q),
      .mem_wr   (mem_flags_q.valid && mem_flags_q.reg_write),
      .mem_dest (mem_dest_q),
      .wb_wr    (wb_flags_q.valid && wb_flags_q.reg_write),
      .wb_dest  (wb_dest_q),
      .sel      (ForwardB)
   );

   assign WbDest     = wb_dest_q;
   assign WbRegWrite = wb_flags_q.valid && wb_flags_q.reg_write;

endmodule
